// File: rtl/sm4_sbox_pipe.sv
// Multi-lane SM4 S-box (tau) with an elastic valid/ready register pipeline.
// Optional macro SM4_SBOX_LT_EN (LANES==4 only) folds L / L' into the last stage.
module sm4_sbox_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 key_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [2:0]           occupancy
);

    localparam int unsigned W    = 8 * LANES;
    localparam int unsigned LAST = STAGES - 1;
`ifdef SM4_SBOX_LT_EN
    localparam bit LT_EN = (LANES == 4);
`else
    localparam bit LT_EN = 1'b0;
`endif

    // SM4 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

`ifdef SM4_SBOX_LT_EN
    function automatic logic [31:0] lt_f(input logic [31:0] b, input logic k);
        if (k)
            return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
    endfunction
`endif

    logic [W-1:0] tau_c;
    logic         vld [STAGES];
    logic         acc [STAGES];
    logic         km  [STAGES];
    logic [W-1:0] dat [STAGES];
    logic         last_sk;
    logic         in_xfer;
    logic         out_xfer;
    logic         unused_km;

    always_comb begin
        tau_c = '0;
        for (int i = 0; i < int'(LANES); i++)
            tau_c[8*i +: 8] = sbox(in_data[8*i +: 8]);
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic         sv;
        logic [W-1:0] sd;
        logic         sk;
        logic [W-1:0] ld;

        if (k == 0) begin : g_src_in
            assign sv = in_valid;
            assign sd = tau_c;
            assign sk = key_mode;
        end else begin : g_src_prev
            assign sv = vld[k-1];
            assign sd = dat[k-1];
            assign sk = km[k-1];
        end

        // Accept chain ripples back from the output handshake
        if (k == int'(LAST)) begin : g_tail
            assign acc[k]  = !vld[k] || out_ready;
            assign last_sk = sk;
            if (LT_EN) begin : g_lt
`ifdef SM4_SBOX_LT_EN
                assign ld = lt_f(sd, sk);
`else
                assign ld = sd;
`endif
            end else begin : g_nolt
                assign ld = sd;
            end
        end else begin : g_mid
            assign acc[k] = !vld[k] || acc[k+1];
            assign ld     = sd;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld[k] <= 1'b0;
                km[k]  <= 1'b0;
                dat[k] <= '0;
            end else if (acc[k]) begin
                vld[k] <= sv;
                km[k]  <= sk;
                dat[k] <= ld;
            end
        end
    end

    assign in_ready  = acc[0] && !rst;
    assign out_valid = vld[LAST];
    assign out_data  = dat[LAST];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = vld[LAST] && out_ready;
    assign unused_km = km[LAST] ^ last_sk;

    always_ff @(posedge clk) begin
        if (rst)
            occupancy <= 3'd0;
        else if (in_xfer && !out_xfer)
            occupancy <= occupancy + 3'd1;
        else if (out_xfer && !in_xfer)
            occupancy <= occupancy - 3'd1;
    end

endmodule

// File: tb/tb_sm4_sbox_pipe.sv
// Directed self-checking bench for sm4_sbox_pipe (LANES=4, STAGES=2).
module tb_sm4_sbox_pipe;

    localparam int unsigned LANES  = 4;
    localparam int unsigned STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        key_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_ref [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    always #5 clk = ~clk;

    sm4_sbox_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_mode  (key_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tau(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sbox_ref[w[8*i +: 8]];
        return r;
    endfunction

`ifdef SM4_SBOX_LT_EN
    function automatic logic [31:0] rol(input logic [31:0] b, input int n);
        return (b << n) | (b >> (32 - n));
    endfunction
`endif

    // Expected output for key_mode=0
    function automatic logic [31:0] model(input logic [31:0] w);
        logic [31:0] t;
        t = tau(w);
`ifdef SM4_SBOX_LT_EN
        return t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
`else
        return t;
`endif
    endfunction

    function automatic logic [31:0] word_of(input int j, input bit exh);
        if (exh)
            return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
        return {4{8'(j)}};
    endfunction

    // Back-to-back stream with out_ready=1: result of word j appears two edges after it is offered
    task automatic stream(input int n, input bit exh);
        for (int j = 0; j < n + 2; j++) begin
            @(posedge clk);
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (j >= 2) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", out_data, model(word_of(j - 2, exh)));
            end
            if (j < n) begin
                in_valid = 1'b1;
                in_data  = word_of(j, exh);
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
    endtask

    logic [31:0] tau_exp, lt0_exp, lt1_exp;
    logic [31:0] w0, w1, w2;

    initial begin
`ifdef SM4_SBOX_LT_EN
        tau_exp = model(32'h0001abff);
        lt0_exp = 32'h01040405;
        lt1_exp = 32'h00802001;
`else
        tau_exp = 32'hd690ab48;
        lt0_exp = 32'h00000001;
        lt1_exp = 32'h00000001;
`endif
        w0 = 32'h00112233;
        w1 = 32'h44556677;
        w2 = 32'h8899aabb;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word, latency exactly two cycles
        in_valid = 1'b1;
        in_data  = 32'h0001abff;
        tick();
        in_valid = 1'b0;
        check("tau_lat1_valid", 32'(out_valid), 32'd0);
        check("tau_lat1_occ", 32'(occupancy), 32'd1);
        tick();
        check("tau_valid", 32'(out_valid), 32'd1);
        check("tau_data", out_data, tau_exp);
        tick();
        check("tau_drained_valid", 32'(out_valid), 32'd0);
        check("tau_drained_occ", 32'(occupancy), 32'd0);

        // Linear transform selection, key_mode travels with its word
        in_valid = 1'b1;
        in_data  = 32'h7171716c;
        key_mode = 1'b0;
        tick();
        key_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        key_mode = 1'b0;
        check("lt_l_data", out_data, lt0_exp);
        tick();
        check("lt_lp_valid", 32'(out_valid), 32'd1);
        check("lt_lp_data", out_data, lt1_exp);
        tick();

        // Streaming 00..0f per lane, then every byte value
        stream(16, 1'b0);
        stream(64, 1'b1);
        check("stream_end_occ", 32'(occupancy), 32'd0);

        // Back-pressure: two accepted, third stalls, then full-pipe simultaneous transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w0;
        tick();
        check("bp_occ1", 32'(occupancy), 32'd1);
        in_data = w1;
        tick();
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_data = w2;
        tick();
        check("bp_hold_occ", 32'(occupancy), 32'd2);
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_data", out_data, model(w0));
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_full_xfer_occ", 32'(occupancy), 32'd2);
        check("bp_word1", out_data, model(w1));
        tick();
        check("bp_word2", out_data, model(w2));
        check("bp_occ_dec", 32'(occupancy), 32'd1);
        tick();
        check("bp_empty_valid", 32'(out_valid), 32'd0);
        check("bp_empty_occ", 32'(occupancy), 32'd0);

        // Reset mid-stream with two words in flight and a third offered
        in_valid = 1'b1;
        in_data  = w0;
        tick();
        in_data = w1;
        tick();
        check("mr_pre_occ", 32'(occupancy), 32'd2);
        in_data = w2;
        rst     = 1'b1;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_occupancy", 32'(occupancy), 32'd0);
        check("mr_out_data", out_data, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mr_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("mr_discard_valid", 32'(out_valid), 32'd0);
        check("mr_discard_occ", 32'(occupancy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
